// File: rtl/instruction_loader.sv
// instruction_loader: boot-time loader that streams a program image into the
// instruction RAM write port and keeps the CPU stalled until a load succeeds.
// Ports: clock, reset (sync, active-high); start pulse; byte_valid/byte_data
// stream in with byte_ready; wr_en/wr_address/wr_data RAM write port;
// busy/done/error status; cpu_hold stall request.
// Optional feature: define LOADER_CHECKSUM_EN for a trailing XOR check byte.
// Stream format: 16-bit word count (MSB first), then 32-bit words MSB-first.
module instruction_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 70
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, COUNT_HI, COUNT_LO, DATA, CHECK, DONE, ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, COUNT_HI, COUNT_LO, DATA, DONE, ERROR
    } state_t;
`endif

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_address_d;
    logic [31:0]           wr_data_d;
    logic                  loading_d;
    logic                  accept;
    logic [15:0]           count_full;
    logic                  last_word;
    state_t                after_data;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    assign accept     = byte_valid && byte_ready;
    assign count_full = {count_q[15:8], byte_data};
    assign last_word  = (16'(word_idx_q) == count_q - 16'd1);

`ifdef LOADER_CHECKSUM_EN
    assign after_data = CHECK;
`else
    assign after_data = DONE;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address;
        wr_data_d    = wr_data;
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A byte arriving with start is dropped: byte_ready is low.
                if (start) state_d = COUNT_HI;
            end
            COUNT_HI: begin
                if (accept) begin
                    count_d = {byte_data, count_q[7:0]};
                    state_d = COUNT_LO;
                end
            end
            COUNT_LO: begin
                if (accept) begin
                    count_d    = count_full;
                    word_idx_d = '0;
                    byte_idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = 8'h00;
`endif
                    if (count_full > DEPTH16)
                        state_d = ERROR;
                    else if (count_full == 16'd0)
                        state_d = after_data;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    asm_d      = {asm_q[15:0], byte_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ byte_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d      = 1'b1;
                        wr_data_d    = {asm_q, byte_data};
                        wr_address_d = word_idx_q;
                        word_idx_d   = word_idx_q + ADDR_WIDTH'(1);
                        if (last_word) state_d = after_data;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept)
                    state_d = (byte_data == xor_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start) state_d = COUNT_HI;
            end
            default: state_d = IDLE;
        endcase

        loading_d = (state_d == COUNT_HI) || (state_d == COUNT_LO) ||
                    (state_d == DATA);
`ifdef LOADER_CHECKSUM_EN
        loading_d = loading_d || (state_d == CHECK);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 16'd0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= 32'd0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_en      <= wr_en_d;
            wr_address <= wr_address_d;
            wr_data    <= wr_data_d;
            byte_ready <= loading_d;
            busy       <= loading_d;
            done       <= (state_d == DONE);
            error      <= (state_d == ERROR);
            cpu_hold   <= (state_d != DONE);
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized image loads checked against
// a queue-based image model (expected writes, status and checksum outcome).
module tb_instruction_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 70;

    logic          clock;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] img[$];
    logic [31:0] got_a[$];
    logic [31:0] got_d[$];

    instruction_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM-side monitor: every write strobe seen away from the active edge.
    always @(negedge clock) begin
        if (wr_en) begin
            got_a.push_back(32'(wr_address));
            got_d.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        start      = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
    endtask

    // Loads img with header count cnt and checks the outcome against the
    // image model: all words written in order unless the count is rejected.
    task automatic run_load(input int cnt, input bit bad_ck,
                            input bit mid_start, input bit with_byte);
        logic [7:0] x;
        logic [7:0] b;
        bit         exp_err;
        int         n;
        int         waited;
        x = 8'h00;
        got_a.delete();
        got_d.delete();
        start = 1'b1;
        if (with_byte) begin
            byte_valid = 1'b1;
            byte_data  = 8'hFF;
        end
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(byte_ready), 32'd1);
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("done_clear", 32'(done), 32'd0);
        send(8'(cnt >> 8));
        send(8'(cnt));
        exp_err = (cnt > DEPTH);
        if (!exp_err) begin
            for (int w = 0; w < cnt; w++) begin
                for (int k = 3; k >= 0; k--) begin
                    b = img[w][8*k +: 8];
                    x ^= b;
                    if (mid_start && w == 0 && k == 2) start = 1'b1;
                    send(b);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send(bad_ck ? (x ^ 8'h22) : x);
            if (bad_ck) exp_err = 1'b1;
`endif
        end
        waited = 0;
        while (!(done || error) && waited < 20) begin
            tick();
            waited++;
        end
        chk("finish_in_time", 32'(waited < 20), 32'd1);
        tick();
        tick();
        chk("done", 32'(done), 32'(!exp_err));
        chk("error", 32'(error), 32'(exp_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(exp_err));
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(byte_ready), 32'd0);
        chk("wr_en_end", 32'(wr_en), 32'd0);
        n = (cnt > DEPTH) ? 0 : cnt;
        chk("write_count", 32'(got_a.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_a.size()) begin
                chk("write_addr", got_a[i], 32'(i));
                chk("write_data", got_d[i], img[i]);
            end
        end
        if (n > 0) begin
            chk("addr_hold", 32'(wr_address), 32'(n - 1));
            chk("data_hold", wr_data, img[n-1]);
        end
    endtask

    task automatic rand_img(input int cnt);
        img.delete();
        for (int i = 0; i < cnt; i++) img.push_back($urandom);
    endtask

    initial begin
        int cnt;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_address), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        got_a.delete();
        got_d.delete();
        repeat (10) tick();
        chk("idle_no_write", 32'(got_a.size()), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        img = '{32'h48000006, 32'h50600012};
        run_load(2, 1'b0, 1'b0, 1'b0);

        run_load(71, 1'b0, 1'b0, 1'b0);
        rand_img(3);
        run_load(3, 1'b0, 1'b0, 1'b0);

        got_a.delete();
        got_d.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00);
        send(8'h01);
        send(8'hDE);
        send(8'hAD);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        send(8'hBE);
        send(8'hEF);
        repeat (3) tick();
        chk("midrst_no_write", 32'(got_a.size()), 32'd0);
        chk("midrst_ready2", 32'(byte_ready), 32'd0);

        img = '{32'hDEADBEEF};
        run_load(1, 1'b1, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        rand_img(2);
        run_load(2, 1'b0, 1'b0, 1'b1);

        rand_img(3);
        run_load(3, 1'b0, 1'b1, 1'b0);

        img.delete();
        run_load(0, 1'b0, 1'b0, 1'b0);

        rand_img(DEPTH);
        run_load(DEPTH, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                cnt = $urandom_range(DEPTH + 1, 65535);
                img.delete();
            end else begin
                cnt = $urandom_range(0, 8);
                rand_img(cnt);
            end
            run_load(cnt, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
